// File: rtl/adc_test_pkg.sv
// Shared constants, pattern encoding and the single-step LFSR function
// for the synthetic ADC data source.
package adc_test_pkg;

  localparam int LANE_W   = 16;
  localparam int SAMPLE_W = 14;
  localparam int LANES    = 4;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_CONST = 2'd2
  } pattern_e;

  // Taps of x^16+x^14+x^13+x^11+1 expressed as state bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adc_test_lfsr.sv
// Fibonacci LFSR advancing four steps per clock; exposes the low 14 bits
// of each intermediate state as one sample per lane.
module adc_test_lfsr
  import adc_test_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [LANES-1:0][SAMPLE_W-1:0]     samples
);

  // An all-zero state would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state;
  logic [15:0] next_state;

  always_comb begin
    logic [15:0] s;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    samples    = '0;
    next_state = state;
    s          = state;
    for (int k = 0; k < LANES; k++) begin
      s          = lfsr_step(s);
      samples[k] = s[SAMPLE_W-1:0];
    end
    next_state = s;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEED_EFF;
    else        state <= next_state;
  end

endmodule

// File: rtl/adc_test.sv
// Synthetic four-lane 14-bit ADC: ramp, LFSR or constant samples packed
// with lane tags into one registered 64-bit word per clock.
module adc_test
  import adc_test_pkg::*;
#(
  parameter int          PATTERN     = 0,
  parameter logic [13:0] CONST_VALUE = 14'h2AAA,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        i_62clk,
  input  logic        i_nreset,
  output logic [63:0] o_data
);

  // Unknown PATTERN values fall back to ramp.
  localparam pattern_e MODE = (PATTERN == 1) ? PAT_LFSR  :
                              (PATTERN == 2) ? PAT_CONST : PAT_RAMP;

  logic [SAMPLE_W-1:0]               count;
  logic [LANES-1:0][SAMPLE_W-1:0]    lfsr_samples;
  logic [LANES-1:0][LANE_W-1:0]      next_data;
  logic [LANES-1:0][LANE_W-1:0]      data;
  logic [SAMPLE_W-1:0]               sample;

  adc_test_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (i_62clk),
    .rst_n   (i_nreset),
    .samples (lfsr_samples)
  );

  always_comb begin
    next_data = '0;
    sample    = '0;
    for (int k = 0; k < LANES; k++) begin
      case (MODE)
        PAT_LFSR:  sample = lfsr_samples[k];
        PAT_CONST: sample = CONST_VALUE;
        default:   sample = count + SAMPLE_W'(k);
      endcase
      next_data[k] = {2'(k), sample};
    end
  end

  // Counter wraps silently modulo 2^14; output clears asynchronously in reset.
  always_ff @(posedge i_62clk or negedge i_nreset) begin
    if (!i_nreset) begin
      count <= '0;
      data  <= '0;
    end else begin
      count <= count + SAMPLE_W'(LANES);
      data  <= next_data;
    end
  end

  assign o_data = data;

endmodule

// File: tb/tb_adc_test.sv
// Directed bench for adc_test: one instance per pattern, checked against
// hand-derived words and a small independent LFSR model.
module tb_adc_test;

  logic        clk;
  logic        rst_n;
  logic [63:0] d_ramp, d_alt, d_lfsr, d_lfsr0, d_const;

  int checks   = 0;
  int failures = 0;

  adc_test #(.PATTERN(0)) u_ramp (
    .i_62clk(clk), .i_nreset(rst_n), .o_data(d_ramp));
  adc_test #(.PATTERN(3)) u_alt (
    .i_62clk(clk), .i_nreset(rst_n), .o_data(d_alt));
  adc_test #(.PATTERN(1), .LFSR_SEED(16'hACE1)) u_lfsr (
    .i_62clk(clk), .i_nreset(rst_n), .o_data(d_lfsr));
  adc_test #(.PATTERN(1), .LFSR_SEED(16'h0000)) u_lfsr0 (
    .i_62clk(clk), .i_nreset(rst_n), .o_data(d_lfsr0));
  adc_test #(.PATTERN(2), .CONST_VALUE(14'h2AAA)) u_const (
    .i_62clk(clk), .i_nreset(rst_n), .o_data(d_const));

  initial clk = 1'b0;
  always #8 clk = ~clk;

  function automatic logic [63:0] ramp_word(input logic [13:0] c);
    logic [63:0] w;
    logic [13:0] s;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      s = c + 14'(k);
      w[16*k +: 16] = {2'(k), s};
    end
    return w;
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [63:0] lfsr_word(input logic [15:0] s0);
    logic [63:0] w;
    logic [15:0] s;
    w = '0;
    s = s0;
    for (int k = 0; k < 4; k++) begin
      s = ref_step(s);
      w[16*k +: 16] = {2'(k), s[13:0]};
    end
    return w;
  endfunction

  function automatic logic [15:0] lfsr_adv4(input logic [15:0] s0);
    logic [15:0] s;
    s = s0;
    for (int k = 0; k < 4; k++) s = ref_step(s);
    return s;
  endfunction

  // Assert reset away from the clock edge, hold it, release just after a falling edge.
  task automatic do_reset(input int hold_ns);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #(hold_ns);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #300;
    checks++;
    if (d_ramp !== 64'h0 || d_lfsr !== 64'h0 || d_const !== 64'h0) begin
      failures++;
      $display("FAIL reset_zero: ramp=%h lfsr=%h const=%h expected 0", d_ramp, d_lfsr, d_const);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d_ramp !== 64'hC003_8002_4001_0000) begin
      failures++;
      $display("FAIL first_word: got %h expected %h", d_ramp, 64'hC003_8002_4001_0000);
    end
    checks++;
    if (d_alt !== 64'hC003_8002_4001_0000) begin
      failures++;
      $display("FAIL pattern3_first_word: got %h expected %h", d_alt, 64'hC003_8002_4001_0000);
    end
    @(negedge clk);
    checks++;
    if (d_ramp !== 64'hC007_8006_4005_0004) begin
      failures++;
      $display("FAIL second_word: got %h expected %h", d_ramp, 64'hC007_8006_4005_0004);
    end
  endtask

  task automatic test_ramp_wrap();
    logic [13:0] c;
    logic [63:0] prev;
    bit          wrap_seen;
    do_reset(40);
    c         = 14'd0;
    prev      = '0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      checks++;
      if (d_ramp !== ramp_word(c) || d_alt !== ramp_word(c)) begin
        failures++;
        $display("FAIL ramp_word[%0d]: ramp=%h alt=%h expected %h", i, d_ramp, d_alt, ramp_word(c));
      end
      if (prev == 64'hFFFF_BFFE_7FFD_3FFC) begin
        wrap_seen = 1'b1;
        checks++;
        if (d_ramp !== 64'hC003_8002_4001_0000) begin
          failures++;
          $display("FAIL ramp_wrap: got %h expected %h", d_ramp, 64'hC003_8002_4001_0000);
        end
      end
      prev = d_ramp;
      c    = c + 14'd4;
    end
    checks++;
    if (!wrap_seen) begin
      failures++;
      $display("FAIL ramp_wrap_seen: got 0 expected 1");
    end
  endtask

  task automatic test_midstream_reset();
    do_reset(40);
    repeat (62) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (d_ramp !== 64'h0 || d_lfsr !== 64'h0 || d_const !== 64'h0) begin
      failures++;
      $display("FAIL async_reset: ramp=%h lfsr=%h const=%h expected 0", d_ramp, d_lfsr, d_const);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (d_ramp !== 64'hC003_8002_4001_0000) begin
      failures++;
      $display("FAIL restart_word: got %h expected %h", d_ramp, 64'hC003_8002_4001_0000);
    end
    checks++;
    if (d_lfsr !== lfsr_word(16'hACE1)) begin
      failures++;
      $display("FAIL lfsr_restart: got %h expected %h", d_lfsr, lfsr_word(16'hACE1));
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] s, s0;
    do_reset(40);
    s  = 16'hACE1;
    s0 = 16'h0001;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      checks++;
      if (d_lfsr !== lfsr_word(s)) begin
        failures++;
        $display("FAIL lfsr_word[%0d]: got %h expected %h", i, d_lfsr, lfsr_word(s));
      end
      checks++;
      if (d_lfsr0 !== lfsr_word(s0)) begin
        failures++;
        $display("FAIL lfsr_seed0[%0d]: got %h expected %h", i, d_lfsr0, lfsr_word(s0));
      end
      s  = lfsr_adv4(s);
      s0 = lfsr_adv4(s0);
    end
  endtask

  task automatic test_const();
    do_reset(40);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (d_const !== 64'hEAAA_AAAA_6AAA_2AAA) begin
        failures++;
        $display("FAIL const_word[%0d]: got %h expected %h", i, d_const, 64'hEAAA_AAAA_6AAA_2AAA);
      end
    end
  endtask

  task automatic test_tags();
    logic [63:0] w [5];
    do_reset(40);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      w[0] = d_ramp; w[1] = d_alt; w[2] = d_lfsr; w[3] = d_lfsr0; w[4] = d_const;
      for (int n = 0; n < 5; n++) begin
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (w[n][16*k+14 +: 2] !== 2'(k)) begin
            failures++;
            $display("FAIL lane_tag inst%0d lane%0d cyc%0d: got %0d expected %0d",
                     n, k, i, w[n][16*k+14 +: 2], k);
          end
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_ramp_wrap();
    test_midstream_reset();
    test_lfsr();
    test_const();
    test_tags();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
